// File: rtl/led_pattern_pkg.sv
// Shared types for the multi-channel LED pattern generator.
// Channel configuration is held at the widest supported counter width.
package led_pattern_pkg;

    localparam int MAX_CNT_W = 32;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_e;

    // Narrower CNT_W values are zero-extended into these fields; the constant upper bits trim away.
    typedef struct packed {
        led_mode_e              mode;
        logic [MAX_CNT_W-1:0]   period;
        logic [MAX_CNT_W-1:0]   duty;
    } chan_cfg_t;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Configuration port of the LED pattern generator: valid/ready request plus error pulse.
interface led_pattern_gen_if
    import led_pattern_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [4:0]         cfg_ch;
    led_mode_e          cfg_mode;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_duty;
    logic               cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/led_tick_gen.sv
// Shared prescaler: one-clock tick every PRESCALE clocks, restartable by sync.
module led_tick_gen #(
    parameter int PRESCALE = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    output logic tick
);
    // A PRESCALE of 1 still needs a 1-bit counter that simply stays at zero.
    localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [TW-1:0] LAST = TW'(PRESCALE - 1);

    logic [TW-1:0] tick_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || sync) begin
            tick_cnt <= '0;
        end else if (tick_cnt == LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM on a shared prescaled tick.
// LED outputs are registered from each channel's next state.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 100_000
) (
    input  logic               clk,
    input  logic               rst,
    led_pattern_gen_if.slave   cfg,
    input  logic               sync,
    output logic [N_CH-1:0]    led
);

    logic            tick;
    logic            accept;
    logic [N_CH-1:0] led_next;

    led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .sync (sync),
        .tick (tick)
    );

    assign accept = cfg.cfg_valid && cfg.cfg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg.cfg_ready <= 1'b0;
            cfg.cfg_err   <= 1'b0;
            led           <= '0;
        end else begin
            cfg.cfg_ready <= 1'b1;
            cfg.cfg_err   <= accept && (int'(cfg.cfg_ch) >= N_CH);
            led           <= led_next;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        chan_cfg_t          cfg_q, cfg_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic               blink_q, blink_d;
        logic               hit, last, led_d;

        always_comb begin
            // NOTE: every combinational output gets a default first so no path infers a latch.
            cfg_d   = cfg_q;
            cnt_d   = cnt_q;
            blink_d = blink_q;
            led_d   = 1'b0;
            hit     = accept && (cfg.cfg_ch == 5'(i));
            last    = (MAX_CNT_W'(cnt_q) == cfg_q.period - MAX_CNT_W'(1));

            if (hit) begin
                cfg_d.mode   = cfg.cfg_mode;
                cfg_d.period = MAX_CNT_W'(cfg.cfg_period);
                cfg_d.duty   = MAX_CNT_W'(cfg.cfg_duty);
            end

            // A config restarts this channel; sync restarts all of them. Either outranks the tick.
            if (hit || sync) begin
                cnt_d   = '0;
                blink_d = 1'b0;
            end else if (tick) begin
                if ((cfg_q.mode == LED_BLINK || cfg_q.mode == LED_PWM) && cfg_q.period != '0) begin
                    if (last) begin
                        cnt_d = '0;
                        if (cfg_q.mode == LED_BLINK) begin
                            blink_d = ~blink_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            unique case (cfg_d.mode)
                LED_OFF:   led_d = 1'b0;
                LED_ON:    led_d = 1'b1;
                LED_BLINK: led_d = blink_d;
                LED_PWM:   led_d = (cfg_d.period != '0) && (MAX_CNT_W'(cnt_d) < cfg_d.duty);
                default:   led_d = 1'b0;
            endcase
        end

        // NOTE: the small per-channel config store is reset explicitly because every mode must power up OFF.
        always_ff @(posedge clk) begin
            if (rst) begin
                cfg_q   <= '{mode: LED_OFF, period: '0, duty: '0};
                cnt_q   <= '0;
                blink_q <= 1'b0;
            end else begin
                cfg_q   <= cfg_d;
                cnt_q   <= cnt_d;
                blink_q <= blink_d;
            end
        end

        assign led_next[i] = led_d;
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized and directed bench for led_pattern_gen against a tick-count reference model.
// The model tracks ticks elapsed since each channel's last restart and derives LED levels arithmetically.
module tb_led_pattern_gen;
    import led_pattern_pkg::*;

    localparam int N_CH     = 4;
    localparam int CNT_W    = 8;
    localparam int PRESCALE = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sync = 1'b0;
    logic [N_CH-1:0] led;

    led_pattern_gen_if #(.CNT_W(CNT_W)) cfg_bus ();

    led_pattern_gen #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cfg  (cfg_bus.slave),
        .sync (sync),
        .led  (led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference state: configuration plus ticks elapsed since the channel last restarted.
    int m_mode  [N_CH];
    int m_per   [N_CH];
    int m_duty  [N_CH];
    int m_ticks [N_CH];
    int m_phase;
    bit m_ready;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit model_led(input int c);
        case (m_mode[c])
            1:       return 1'b1;
            2:       return (m_per[c] > 0) && (((m_ticks[c] / m_per[c]) % 2) == 1);
            3:       return (m_per[c] > 0) && ((m_ticks[c] % m_per[c]) < m_duty[c]);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [N_CH-1:0] model_leds();
        logic [N_CH-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c] = model_led(c);
        return v;
    endfunction

    task automatic model_edge(input bit r, input bit v, input int ch, input int mode,
                              input int per, input int duty, input bit s);
        bit tick_now;
        bit acc;
        tick_now = (m_phase == PRESCALE - 1);
        acc      = v && m_ready;
        if (r) begin
            for (int c = 0; c < N_CH; c++) begin
                m_mode[c] = 0; m_per[c] = 0; m_duty[c] = 0; m_ticks[c] = 0;
            end
            m_phase = 0;
            m_ready = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_err   = acc && (ch >= N_CH);
            m_ready = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                if (acc && ch == c) begin
                    m_mode[c] = mode; m_per[c] = per; m_duty[c] = duty; m_ticks[c] = 0;
                end else if (s) begin
                    m_ticks[c] = 0;
                end else if (tick_now) begin
                    m_ticks[c]++;
                end
            end
            m_phase = s ? 0 : (m_phase + 1) % PRESCALE;
        end
    endtask

    // One clock: drive inputs, advance the model, then sample outputs 1 time unit after the edge.
    task automatic cycle(input bit r, input bit v, input int ch, input int mode,
                         input int per, input int duty, input bit s);
        rst                = r;
        sync               = s;
        cfg_bus.cfg_valid  = v;
        cfg_bus.cfg_ch     = 5'(ch);
        cfg_bus.cfg_mode   = led_mode_e'(mode[1:0]);
        cfg_bus.cfg_period = CNT_W'(per);
        cfg_bus.cfg_duty   = CNT_W'(duty);
        model_edge(r, v, ch, mode, per, duty, s);
        @(posedge clk);
        #1;
        cyc++;
        check("led",       32'(led),              32'(model_leds()));
        check("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(m_ready));
        check("cfg_err",   32'(cfg_bus.cfg_err),   32'(m_err));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic config_ch(input int ch, input int mode, input int per, input int duty);
        cycle(1'b0, 1'b1, ch, mode, per, duty, 1'b0);
    endtask

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            m_mode[c] = 0; m_per[c] = 0; m_duty[c] = 0; m_ticks[c] = 0;
        end
        m_phase = 0; m_ready = 1'b0; m_err = 1'b0;
        cfg_bus.cfg_valid  = 1'b0;
        cfg_bus.cfg_ch     = '0;
        cfg_bus.cfg_mode   = LED_OFF;
        cfg_bus.cfg_period = '0;
        cfg_bus.cfg_duty   = '0;

        // Reset held three cycles, then release.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        idle(3);

        // BLINK on ch0, half-period of 3 ticks.
        config_ch(0, 2, 3, 0);
        idle(60);

        // PWM on ch1, then duty 0 and duty above period.
        config_ch(1, 3, 4, 1);
        idle(40);
        config_ch(1, 3, 4, 0);
        idle(20);
        config_ch(1, 3, 4, 5);
        idle(20);

        // Out-of-range channel.
        config_ch(5, 1, 0, 0);
        idle(3);

        // Two blinkers configured apart, then re-aligned by sync.
        config_ch(0, 2, 2, 0);
        idle(4);
        config_ch(2, 2, 2, 0);
        idle(7);
        cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        idle(40);

        // Reset mid-pattern while ch0 is high; ch0 must stay OFF afterwards.
        for (int k = 0; k < 40 && !model_led(0); k++) idle(1);
        check("blink_high_before_rst", 32'(led[0]), 32'(1));
        cycle(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        idle(20);

        // Randomized traffic including sync, reset, bad channels and zero periods.
        for (int k = 0; k < 3000; k++) begin
            bit r, v, s;
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 5) == 0);
            cycle(r, v, $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 5), $urandom_range(0, 6), s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
